// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, FSM state type and byte-lane helper for the responder.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam int unsigned CNT_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } ahb_state_e;

  // Little-endian byte enables for an aligned transfer.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] off);
    case (size)
      HSIZE_BYTE: return 4'b0001 << off;
      HSIZE_HALF: return off[1] ? 4'b1100 : 4'b0011;
      default:    return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_slave_mem.sv
// Word-organised store: async-reset clear, byte-enable write, combinational read.
module ahb_slave_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ahb_slave_responder.sv
// AHB-Lite responder: window decode, error check, wait-state FSM, byte-lane store access.
module ahb_slave_responder
  import ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hreadyin,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [31:0] haddr,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic [1:0]  hresp
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LIMIT = DEPTH * 4;

  ahb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q;
  logic [1:0]       off_q;
  logic [2:0]       size_q;
  logic             wr_q;
  logic             sel, bad, load;
  logic [3:0]       be;
  logic [31:0]      rd_word;

  logic unused_ok;
  assign unused_ok = ^{hburst, htrans[0]};

  // Address phase is only taken when the previous data phase is finishing.
  assign sel = hreadyin && htrans[1] && (haddr[31:16] == BASE_ADDR[31:16]) &&
               (state_q == ST_IDLE || state_q == ST_DATA || state_q == ST_ERR2);

  assign bad = (hsize > HSIZE_WORD) ||
               ((hsize == HSIZE_HALF) && haddr[0]) ||
               ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00)) ||
               (32'(haddr[15:0]) >= LIMIT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        state_d = ST_IDLE;
        if (sel) begin
          load = 1'b1;
          if (bad) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(WAIT_STATES);
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q <= CNT_W'(1)) state_d = ST_DATA;
        else                    cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      off_q     <= '0;
      size_q    <= '0;
      wr_q      <= 1'b0;
      hreadyout <= 1'b1;
      hresp     <= HRESP_OKAY;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hreadyout <= !(state_d == ST_WAIT || state_d == ST_ERR1);
      hresp     <= (state_d == ST_ERR1 || state_d == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
      if (load) begin
        idx_q  <= haddr[IDX_W+1:2];
        off_q  <= haddr[1:0];
        size_q <= hsize;
        wr_q   <= hwrite;
      end
    end
  end

  // Writes commit on the edge that ends the DATA cycle.
  assign be = (state_q == ST_DATA && wr_q) ? lane_mask(size_q, off_q) : 4'b0000;

  ahb_slave_mem #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_mem (
    .clk   (hclk),
    .rst_n (hresetn),
    .be    (be),
    .waddr (idx_q),
    .wdata (hwdata),
    .raddr (idx_q),
    .rdata (rd_word)
  );

  assign hrdata = (state_q == ST_DATA) ? rd_word : 32'h0;

endmodule

// File: tb/tb_ahb_slave_responder.sv
// Scoreboard bench: three responders (0, 2, 3 wait states) driven by a pipelined master model.
module tb_ahb_slave_responder;

  localparam int DEPTH_T = 16;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic [1:0]  htrans_a [3];
  logic        hwrite_a [3];
  logic [2:0]  hsize_a  [3];
  logic [2:0]  hburst_a [3];
  logic [31:0] haddr_a  [3];
  logic [31:0] hwdata_a [3];
  logic [31:0] hrdata_a [3];
  logic        hready_a [3];
  logic [1:0]  hresp_a  [3];

  always #5 hclk = ~hclk;

  ahb_slave_responder #(.BASE_ADDR(32'h8000_0000), .DEPTH(DEPTH_T), .WAIT_STATES(0)) u_dut0 (
    .hclk(hclk), .hresetn(hresetn), .hreadyin(hready_a[0]), .htrans(htrans_a[0]),
    .hwrite(hwrite_a[0]), .hsize(hsize_a[0]), .hburst(hburst_a[0]), .haddr(haddr_a[0]),
    .hwdata(hwdata_a[0]), .hrdata(hrdata_a[0]), .hreadyout(hready_a[0]), .hresp(hresp_a[0]));

  ahb_slave_responder #(.BASE_ADDR(32'h8000_0000), .DEPTH(DEPTH_T), .WAIT_STATES(2)) u_dut1 (
    .hclk(hclk), .hresetn(hresetn), .hreadyin(hready_a[1]), .htrans(htrans_a[1]),
    .hwrite(hwrite_a[1]), .hsize(hsize_a[1]), .hburst(hburst_a[1]), .haddr(haddr_a[1]),
    .hwdata(hwdata_a[1]), .hrdata(hrdata_a[1]), .hreadyout(hready_a[1]), .hresp(hresp_a[1]));

  ahb_slave_responder #(.BASE_ADDR(32'h8000_0000), .DEPTH(DEPTH_T), .WAIT_STATES(3)) u_dut2 (
    .hclk(hclk), .hresetn(hresetn), .hreadyin(hready_a[2]), .htrans(htrans_a[2]),
    .hwrite(hwrite_a[2]), .hsize(hsize_a[2]), .hburst(hburst_a[2]), .haddr(haddr_a[2]),
    .hwdata(hwdata_a[2]), .hrdata(hrdata_a[2]), .hreadyout(hready_a[2]), .hresp(hresp_a[2]));

  typedef struct {
    logic [1:0]  resp;
    int          waits;
    logic        chk_rd;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] mdl [3][DEPTH_T];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          act      = 0;
  logic        beat_v   = 1'b0;
  logic [31:0] prev_wd  = 32'h0;

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : (d == 1) ? 2 : 3;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, want);
  endtask

  task automatic clear_model();
    for (int d = 0; d < 3; d++)
      for (int w = 0; w < DEPTH_T; w++) mdl[d][w] = 32'h0;
  endtask

  task automatic wait_ready(input int d);
    int g = 0;
    do begin
      @(negedge hclk);
      g++;
    end while (!hready_a[d] && g < 20);
    if (!hready_a[d]) begin
      n_checks++;
      $display("FAIL ready_timeout: dut %0d hreadyout stuck low", d);
    end
    @(posedge hclk);
    #1;
  endtask

  // Present one address phase; the expected response comes from the spec rules on the model.
  task automatic issue(input int d, input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                       input logic [31:0] ad, input logic [31:0] wd);
    exp_t e;
    int   off, nb;
    act         = d;
    htrans_a[d] = tr;
    hwrite_a[d] = wr;
    hsize_a[d]  = sz;
    haddr_a[d]  = ad;
    hburst_a[d] = 3'($urandom_range(0, 7));
    hwdata_a[d] = prev_wd;
    prev_wd     = wd;
    beat_v      = 1'b1;
    e.resp = 2'b00; e.waits = 0; e.chk_rd = 1'b1; e.rdata = 32'h0;
    off = int'(ad[15:0]);
    if (tr[1] && ad[31:16] == 16'h8000) begin
      nb = (sz <= 3'd2) ? (1 << sz) : 0;
      if (nb == 0 || (off % nb) != 0 || off >= 4 * DEPTH_T) begin
        e.resp = 2'b01; e.waits = 1;
      end else begin
        e.waits = ws_of(d);
        if (wr) begin
          e.chk_rd = 1'b0;
          for (int i = 0; i < nb; i++) begin
            int lane = (off % 4) + i;
            mdl[d][off / 4][lane*8 +: 8] = wd[lane*8 +: 8];
          end
        end else begin
          e.rdata = mdl[d][off / 4];
        end
      end
    end
    sb.push_back(e);
    wait_ready(d);
  endtask

  task automatic end_seq(input int d);
    htrans_a[d] = 2'b00;
    hwdata_a[d] = prev_wd;
    beat_v      = 1'b0;
    wait_ready(d);
  endtask

  // Monitor: scores each data phase as it finishes on the active responder.
  initial begin
    bit   dp = 0;
    int   lowcnt = 0;
    exp_t e;
    forever begin
      @(negedge hclk);
      if (!hresetn) begin
        dp = 0; lowcnt = 0;
      end else begin
        if (dp) begin
          if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL sb_empty: data phase with no expected response");
            dp = 0;
          end else if (!hready_a[act]) begin
            lowcnt++;
            chk("wait_resp", 32'(hresp_a[act]), 32'(sb[0].resp));
          end else begin
            e = sb.pop_front();
            chk("resp", 32'(hresp_a[act]), 32'(e.resp));
            chk("waits", lowcnt, e.waits);
            if (e.chk_rd) chk("rdata", hrdata_a[act], e.rdata);
            dp = 0;
          end
        end
        if (hready_a[act] && beat_v) begin
          dp = 1; lowcnt = 0;
        end
      end
    end
  end

  initial begin
    hresetn = 1'b0;
    for (int d = 0; d < 3; d++) begin
      htrans_a[d] = 2'b00; hwrite_a[d] = 1'b0; hsize_a[d] = 3'b000;
      hburst_a[d] = 3'b000; haddr_a[d] = 32'h0; hwdata_a[d] = 32'h0;
    end
    clear_model();
    repeat (3) @(posedge hclk);
    #1 hresetn = 1'b1;
    @(negedge hclk);
    for (int d = 0; d < 3; d++) begin
      chk("rst_hready", 32'(hready_a[d]), 32'd1);
      chk("rst_hresp", 32'(hresp_a[d]), 32'd0);
      chk("rst_hrdata", hrdata_a[d], 32'h0);
    end
    @(posedge hclk); #1;

    // Zero-wait byte write/read, then byte burst assembled into a word.
    issue(0, 2'b10, 1'b1, 3'b000, 32'h8000_0000, 32'h0000_0032);
    issue(0, 2'b10, 1'b0, 3'b000, 32'h8000_0000, 32'h0);
    issue(0, 2'b10, 1'b1, 3'b000, 32'h8000_0000, 32'h0000_0011);
    issue(0, 2'b11, 1'b1, 3'b000, 32'h8000_0001, 32'h0000_2200);
    issue(0, 2'b11, 1'b1, 3'b000, 32'h8000_0002, 32'h0033_0000);
    issue(0, 2'b11, 1'b1, 3'b000, 32'h8000_0003, 32'h4400_0000);
    issue(0, 2'b10, 1'b0, 3'b010, 32'h8000_0000, 32'h0);
    // Error responses leave the store untouched.
    issue(0, 2'b10, 1'b1, 3'b010, 32'h8000_0002, 32'hFFFF_FFFF);
    issue(0, 2'b10, 1'b1, 3'b000, 32'h8000_0040, 32'hFFFF_FFFF);
    issue(0, 2'b10, 1'b0, 3'b010, 32'h8000_0000, 32'h0);
    // IDLE, BUSY and out-of-window beats.
    issue(0, 2'b00, 1'b1, 3'b010, 32'h8000_0000, 32'h1234_5678);
    issue(0, 2'b01, 1'b1, 3'b010, 32'h8000_0000, 32'h1234_5678);
    issue(0, 2'b10, 1'b1, 3'b010, 32'h9000_0000, 32'h1234_5678);
    issue(0, 2'b10, 1'b0, 3'b010, 32'h9000_0000, 32'h0);
    issue(0, 2'b10, 1'b0, 3'b010, 32'h8000_0000, 32'h0);
    end_seq(0);
    chk("dir_word0", mdl[0][0], 32'h4433_2211);

    // Two wait states: word write then back-to-back read.
    issue(1, 2'b10, 1'b1, 3'b010, 32'h8000_0004, 32'hDEAD_BEEF);
    issue(1, 2'b10, 1'b0, 3'b010, 32'h8000_0004, 32'h0);
    issue(1, 2'b10, 1'b1, 3'b001, 32'h8000_0001, 32'h0);
    end_seq(1);

    // Reset asserted in the middle of a waited write.
    issue(2, 2'b10, 1'b1, 3'b010, 32'h8000_0008, 32'h5555_AAAA);
    issue(2, 2'b10, 1'b0, 3'b010, 32'h8000_0008, 32'h0);
    end_seq(2);
    act = 2;
    htrans_a[2] = 2'b10; hwrite_a[2] = 1'b1; hsize_a[2] = 3'b010; haddr_a[2] = 32'h8000_0008;
    @(posedge hclk); #1;
    htrans_a[2] = 2'b00; hwdata_a[2] = 32'hCAFE_F00D;
    @(posedge hclk); #1;
    hresetn = 1'b0;
    #1;
    chk("mid_rst_hready", 32'(hready_a[2]), 32'd1);
    chk("mid_rst_hresp", 32'(hresp_a[2]), 32'd0);
    chk("mid_rst_hrdata", hrdata_a[2], 32'h0);
    clear_model();
    sb.delete();
    prev_wd = 32'h0;
    @(posedge hclk); #1 hresetn = 1'b1;
    @(posedge hclk); #1;
    issue(2, 2'b10, 1'b0, 3'b010, 32'h8000_0008, 32'h0);
    end_seq(2);

    // Randomized traffic on every responder.
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 40; k++) begin
        logic [1:0]  tr;
        logic [2:0]  sz;
        logic [31:0] ad;
        int          s;
        tr = 2'($urandom_range(0, 5) < 4 ? 2 + $urandom_range(0, 1) : $urandom_range(0, 1));
        s  = $urandom_range(0, 9);
        sz = (s < 3) ? 3'd0 : (s < 5) ? 3'd1 : (s < 8) ? 3'd2 : (s == 8) ? 3'd3 : 3'd6;
        if ($urandom_range(0, 9) == 0) ad = 32'h9000_0000 | 32'($urandom_range(0, 'h47));
        else                          ad = 32'h8000_0000 | 32'($urandom_range(0, 'h47));
        issue(d, tr, 1'($urandom_range(0, 1)), sz, ad, $urandom);
      end
      end_seq(d);
    end

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
